// File: rtl/mul_div_if.sv
// Operand/result bundle between the EX stage and the mul/div unit.
// The master launches and kills operations; the slave reports busy/done.
interface mul_div_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, op_a, op_b, kill,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, op_a, op_b, kill,
    output busy, done, result
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply, restoring divide, fixed XLEN+2 cycle latency.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input logic      clk,
  input logic      rst,
  mul_div_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam int DW = 2 * XLEN;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [2:0]      f3_q;
  logic [DW-1:0]   acc_q;
  logic [DW-1:0]   a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] a_raw_q;
  logic [CW-1:0]   cnt_q;
  logic            p_neg_q;
  logic            q_neg_q;
  logic            r_neg_q;
  logic            dz_q;
  logic            ovf_q;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  logic            launch;
  logic            last;
  logic            is_div_op;
  logic            a_sgn;
  logic            b_sgn;
  logic            sa;
  logic            sb;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            dz;
  logic            ovf;

  logic [XLEN-1:0] r_sh;
  logic [XLEN:0]   diff;

  logic [DW-1:0]   prod_f;
  logic [XLEN-1:0] quot_f;
  logic [XLEN-1:0] rem_f;
  logic [XLEN-1:0] sel;

  assign launch = (state_q == IDLE || state_q == DONE)
                  && bus.start && !bus.kill;
  assign last   = (cnt_q == CW'(XLEN - 1));

  // Operand decode and magnitude conversion at launch time
  always_comb begin
    is_div_op = bus.funct3[2];
    a_sgn = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010)
            || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    b_sgn = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100)
            || (bus.funct3 == 3'b110);
    sa    = a_sgn && bus.op_a[XLEN-1];
    sb    = b_sgn && bus.op_b[XLEN-1];
    a_mag = sa ? (~bus.op_a + 1'b1) : bus.op_a;
    b_mag = sb ? (~bus.op_b + 1'b1) : bus.op_b;
    dz    = is_div_op && (bus.op_b == '0);
    ovf   = is_div_op && b_sgn
            && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}})
            && (bus.op_b == {XLEN{1'b1}});
  end

  // One restoring-divide step: shift in next dividend bit, try subtract
  always_comb begin
    r_sh = {acc_q[DW-2:XLEN], a_q[XLEN-1]};
    diff = {acc_q[DW-1], r_sh} - {1'b0, b_q};
  end

  // Sign fix-up and output selection for the FIX state
  always_comb begin
    prod_f = p_neg_q ? (~acc_q + 1'b1) : acc_q;
    quot_f = q_neg_q ? (~acc_q[XLEN-1:0] + 1'b1)
                     : acc_q[XLEN-1:0];
    rem_f  = r_neg_q ? (~acc_q[DW-1:XLEN] + 1'b1)
                     : acc_q[DW-1:XLEN];
    sel    = '0;
    unique case (1'b1)
      (f3_q == 3'b000): sel = prod_f[XLEN-1:0];
      (f3_q[2] == 1'b0 && f3_q[1:0] != 2'b00):
        sel = prod_f[DW-1:XLEN];
      (f3_q[2:1] == 2'b10):
        sel = dz_q  ? {XLEN{1'b1}} :
              ovf_q ? {1'b1, {(XLEN-1){1'b0}}} : quot_f;
      (f3_q[2:1] == 2'b11):
        sel = dz_q  ? a_raw_q :
              ovf_q ? '0 : rem_f;
      default: sel = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; kill wins over everything
  always_comb begin
    state_d = state_q;
    if (bus.kill) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (bus.start) state_d = CALC;
        CALC: if (last) state_d = FIX;
        FIX:  state_d = DONE;
        DONE: state_d = bus.start ? CALC : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Status flops, driven from the next state so they track the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d == CALC) || (state_d == FIX);
      done_q <= (state_d == DONE);
    end
  end

  // Datapath: latch operands, iterate, register the result in FIX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3_q     <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      a_raw_q  <= '0;
      cnt_q    <= '0;
      p_neg_q  <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else if (launch) begin
      f3_q     <= bus.funct3;
      acc_q    <= '0;
      a_q      <= {{XLEN{1'b0}}, a_mag};
      b_q      <= b_mag;
      a_raw_q  <= bus.op_a;
      cnt_q    <= '0;
      p_neg_q  <= sa ^ sb;
      q_neg_q  <= sa ^ sb;
      r_neg_q  <= sa;
      dz_q     <= dz;
      ovf_q    <= ovf;
    end else if (!bus.kill && state_q == CALC) begin
      cnt_q <= cnt_q + 1'b1;
      a_q   <= a_q << 1;
      if (f3_q[2]) begin
        if (!diff[XLEN]) begin
          acc_q <= {diff[XLEN-1:0],
                    acc_q[XLEN-2:0], 1'b1};
        end else begin
          acc_q <= {r_sh, acc_q[XLEN-2:0], 1'b0};
        end
      end else begin
        b_q <= b_q >> 1;
        if (b_q[0]) acc_q <= acc_q + a_q;
      end
    end else if (!bus.kill && state_q == FIX) begin
      result_q <= sel;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit.
// Table-driven ops plus kill, back-to-back and reset sequences.
module tb_mul_div_unit;
  logic clk;
  logic rst;

  mul_div_if #(.XLEN(32)) bus ();

  mul_div_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[19];
  logic [31:0] sb[$];
  int          total;
  int          bad;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] f3,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [31:0] exp);
    bus.funct3 = f3;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.start  = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op_a  = $urandom;
    bus.op_b  = $urandom;
  endtask

  // Waits (from a post-edge point) for done; checks busy, latency, result
  task automatic wait_done(input string name, input int lat0);
    int          lat;
    logic        bz_ok;
    logic [31:0] exp;
    lat   = lat0;
    bz_ok = 1'b1;
    while (1) begin
      @(negedge clk);
      lat++;
      if (bus.done) break;
      if (bus.busy !== (lat <= 33)) bz_ok = 1'b0;
      if (lat > 100) break;
    end
    chk({name, " latency"}, 32'(lat), 32'd34);
    chk({name, " busy"}, {31'd0, bz_ok}, 32'd1);
    chk({name, " busy_in_done"}, {31'd0, bus.busy}, 32'd0);
    if (sb.size() == 0) begin
      chk({name, " scoreboard"}, 32'd0, 32'd1);
    end else begin
      exp = sb.pop_front();
      chk({name, " result"}, bus.result, exp);
    end
  endtask

  task automatic no_done(input string name, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk({name, " no_done"}, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [31:0] keep;
    total = 0;
    bad   = 0;
    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
    vecs[6]  = '{3'b101, 32'd100,      32'd0,        32'hFFFFFFFF};
    vecs[7]  = '{3'b111, 32'd100,      32'd0,        32'd100};
    vecs[8]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[9]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0};
    vecs[10] = '{3'b011, 32'h00010000, 32'h00010000, 32'd1};
    vecs[11] = '{3'b000, 32'h00010000, 32'h00010000, 32'd0};
    vecs[12] = '{3'b101, 32'd20,       32'd3,        32'd6};
    vecs[13] = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD};
    vecs[14] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1};
    vecs[15] = '{3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF};
    vecs[16] = '{3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB};
    vecs[17] = '{3'b001, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF};
    vecs[18] = '{3'b000, 32'd12345,    32'd1000,     32'd12345000};

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.kill   = 1'b0;
    bus.funct3 = '0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset result", bus.result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      start_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);
      wait_done($sformatf("vec%0d", i), 0);
      @(negedge clk);
    end

    // kill at cycle 10 of a DIV, then a normal op
    keep = bus.result;
    start_op(3'b100, 32'd1000, 32'd7, 32'd0);
    void'(sb.pop_back());
    repeat (9) @(negedge clk);
    bus.kill = 1'b1;
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    @(negedge clk);
    chk("kill busy", {31'd0, bus.busy}, 32'd0);
    no_done("kill", 40);
    chk("kill result", bus.result, keep);
    start_op(3'b100, 32'd1000, 32'd7, 32'd142);
    wait_done("after_kill", 0);
    @(negedge clk);

    // back-to-back: start REMU in the DONE cycle of DIVU
    start_op(3'b101, 32'd20, 32'd3, 32'd6);
    wait_done("b2b_divu", 0);
    start_op(3'b111, 32'd20, 32'd3, 32'd2);
    wait_done("b2b_remu", 0);
    @(negedge clk);

    // start during CALC is ignored
    start_op(3'b110, 32'd100, 32'd7, 32'd2);
    repeat (4) @(negedge clk);
    bus.funct3 = 3'b000;
    bus.op_a   = 32'd3;
    bus.op_b   = 32'd3;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("calc_start", 4);
    no_done("calc_start", 40);

    // async reset in the middle of a MUL
    start_op(3'b000, 32'd9, 32'd9, 32'd0);
    void'(sb.pop_back());
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    chk("rst done", {31'd0, bus.done}, 32'd0);
    chk("rst result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    no_done("rst", 50);
    chk("rst result hold", bus.result, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative RV32M multiply/divide execution unit in the EX stage, downstream of the ALU operand-select muxes. It receives the forwarded/selected operands A and B on the same 32-bit paths that feed the ALU. It computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles. It drives `busy` to the hazard unit so that IF/ID/EX stall until `done`.

## Interface
- `XLEN`, 32, operand/result width; all arithmetic rules below are stated for XLEN=32.
- `clk`  input  1  single clock, rising-edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  launch request; sampled on rising `clk`.
- `funct3`  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  input  XLEN  rs1 operand (output of the operand-A mux).
- `op_b`  input  XLEN  rs2 operand (output of the operand-B mux).
- `kill`  input  1  pipeline flush; aborts the operation in flight.
- `busy`  output  1  operation in progress; the hazard unit stalls the pipeline while high.
- `done`  output  1  one-cycle pulse; `result` is valid in this cycle.
- `result`  output  XLEN  product/quotient/remainder; holds its last value until the next `done`.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE/DONE + `start`=1 + `kill`=0 -> CALC.
  - Latch `funct3`, the operand magnitudes, and the result-sign flags.
  - Clear the 64-bit accumulator and set the iteration counter to 0.
- Signed/unsigned rules:
  - `op_a` is treated as signed for MULH, MULHSU, DIV, REM.
  - `op_b` is treated as signed for MULH, DIV, REM.
  - Signed operands are converted to magnitude at latch time.
  - Product sign is sign(a) XOR sign(b).
  - Quotient sign is sign(a) XOR sign(b); remainder sign is sign(a).
- CALC, multiply: one shift-add step per cycle on the magnitudes for XLEN cycles, producing a 64-bit unsigned product.
- CALC, divide: one restoring shift-subtract step per cycle for XLEN cycles, producing an unsigned quotient and remainder.
- Counter == XLEN-1 in CALC -> FIX.
- FIX: apply two's-complement negation per the sign flags, then select the output:
  - MUL selects the low 32 bits.
  - MULH, MULHSU, MULHU select the high 32 bits.
  - DIV, DIVU select the quotient.
  - REM, REMU select the remainder.
  - Register the selection into `result`, then go to DONE.
- Special cases are decided at latch time and still take the full latency, so latency is deterministic:
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return `op_a`.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- DONE: `done`=1 for exactly one cycle.
  - Next state is IDLE, or CALC if a new `start` arrives in that cycle (back-to-back launch).
- `start` while in CALC or FIX is ignored.
- `kill`=1 in any state -> IDLE on the next edge.
  - No `done` pulse is produced and `result` is not updated.
  - `kill` has priority over `start` in the same cycle.
- Reset mid-operation: the unit returns to IDLE immediately (asynchronous) and the operation is discarded.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, counter 0.
- `busy` = (state == CALC or FIX), registered. It goes high in the cycle after the `start` edge and stays low in DONE.
- Latency: `start` sampled at edge E0 -> CALC spans E1..E32 -> FIX at E33 -> `done`=1 during the cycle after E33.
  - That is XLEN+2 = 34 cycles from the `start` edge to the `done` cycle.
- Operands are captured only at E0; `op_a` and `op_b` may change afterwards with no effect.
- Back-to-back: `start` in the DONE cycle gives `busy` high in the next cycle and introduces zero idle cycles.
- All outputs are driven directly from flops; there are no combinational paths from inputs to outputs.

## Test plan
- MUL 7 × -3 (op_a=7, op_b=0xFFFFFFFD) -> `done` exactly 34 cycles after `start`; `result`=0xFFFFFFEB. Also check `busy` high for cycles 1..33.
- MULH 0x80000000 × 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100; DIV 0x80000000/-1 -> 0x80000000 and REM -> 0. All cases keep the same 34-cycle latency.
- `kill` at cycle 10 of a DIV -> state IDLE next cycle; no `done`; `result` unchanged. A new `start` afterwards completes normally.
- Back-to-back ops: DIVU 20/3 then `start` REMU 20/3 in the DONE cycle -> results 6 then 2, with `done` pulses exactly 34 cycles apart. A `start` asserted during CALC is ignored.
- Assert `rst` at cycle 15 mid-MUL -> `busy`, `done`, `result` go to 0 asynchronously; no `done` after reset is released.
